// File: rtl/pipe_stage_skid_pkg.sv
// ----------------------------------------------------------------------------
// pipe_stage_skid_pkg
// Shared definitions for the pipeline stage buffers: the skid-buffer state
// encoding, the default bubble control value, per-boundary bundle widths and
// the bit positions used to pack and unpack the control/data bundles.
// ----------------------------------------------------------------------------
package pipe_stage_skid_pkg;

    // State value equals the number of held entries, so occupancy is a
    // direct readout of the state register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    // Control value that encodes a bubble (all write/read enables off).
    localparam logic [7:0] NOP_CTRL_ENC = 8'h00;

    // Control bundle bit positions (shared by every boundary).
    localparam int unsigned CTRL_REGWR_BIT  = 0;
    localparam int unsigned CTRL_MEMWR_BIT  = 1;
    localparam int unsigned CTRL_MEMRD_BIT  = 2;
    localparam int unsigned CTRL_WBSEL_BIT  = 3;
    localparam int unsigned CTRL_ALUOP_LSB  = 4;
    localparam int unsigned CTRL_ALUOP_MSB  = 7;

    // IF/ID: instruction word and next PC.
    localparam int unsigned IF_ID_CTRL_W    = 8;
    localparam int unsigned IF_ID_DATA_W    = 64;
    localparam int unsigned IF_ID_IR_LSB    = 0;
    localparam int unsigned IF_ID_NPC_LSB   = 32;

    // ID/EX: operand A, operand B, immediate, destination register index.
    localparam int unsigned ID_EX_CTRL_W    = 8;
    localparam int unsigned ID_EX_DATA_W    = 101;
    localparam int unsigned ID_EX_A_LSB     = 0;
    localparam int unsigned ID_EX_B_LSB     = 32;
    localparam int unsigned ID_EX_IMM_LSB   = 64;
    localparam int unsigned ID_EX_RD_LSB    = 96;

    // EX/MEM: ALU result, store data, destination register index.
    localparam int unsigned EX_MEM_CTRL_W   = 8;
    localparam int unsigned EX_MEM_DATA_W   = 69;
    localparam int unsigned EX_MEM_ALU_LSB  = 0;
    localparam int unsigned EX_MEM_B_LSB    = 32;
    localparam int unsigned EX_MEM_RD_LSB   = 64;

    // MEM/WB: write-back value, destination register index.
    localparam int unsigned MEM_WB_CTRL_W   = 8;
    localparam int unsigned MEM_WB_DATA_W   = 37;
    localparam int unsigned MEM_WB_RES_LSB  = 0;
    localparam int unsigned MEM_WB_RD_LSB   = 32;

    // Number of held entries for a given state.
    function automatic logic [1:0] occ_of_state(input skid_state_e s);
        logic [1:0] occ;
        case (s)
            ST_EMPTY: occ = 2'd0;
            ST_ONE:   occ = 2'd1;
            ST_TWO:   occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// ----------------------------------------------------------------------------
// pipe_entry_reg
// One pipeline entry (control + data bundle) with load enable and an
// asynchronous active-low clear to NOP_CTRL / 0.
// Ports:
//   clk, reset      - clock, asynchronous active-low clear
//   load            - capture ctrl_d/data_d on the rising edge
//   ctrl_d, data_d  - next entry value
//   ctrl_q, data_q  - stored entry value
// ----------------------------------------------------------------------------
module pipe_entry_reg
    import pipe_stage_skid_pkg::*;
#(
    parameter int unsigned         CTRL_W   = 8,
    parameter int unsigned         DATA_W   = 96,
    parameter logic [CTRL_W-1:0]   NOP_CTRL = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DATA_W-1:0] data_q
);

    logic [CTRL_W-1:0] ctrl_r;
    logic [DATA_W-1:0] data_r;

    // Entry storage: cleared to a bubble on reset, updated only when loaded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_r <= NOP_CTRL;
            data_r <= {DATA_W{1'b0}};
        end else if (load) begin
            ctrl_r <= ctrl_d;
            data_r <= data_d;
        end
    end

    assign ctrl_q = ctrl_r;
    assign data_q = data_r;

endmodule

// File: rtl/pipe_stage_skid.sv
// ----------------------------------------------------------------------------
// pipe_stage_skid
// Pipeline stage buffer with valid/ready handshake and a 2-entry skid buffer.
// Back-pressure is absorbed by the skid register, so in_ready never depends
// combinationally on out_ready. flush turns every held entry into a bubble.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   flush                 - synchronous kill of all held entries
//   in_valid/in_ready     - upstream handshake (in_ready is a flop)
//   in_ctrl/in_data       - upstream control/data bundle
//   out_valid/out_ready   - downstream handshake (out_valid is a flop)
//   out_ctrl/out_data     - head entry (out_ctrl = NOP_CTRL when invalid)
//   occupancy             - number of held entries (0..2)
// ----------------------------------------------------------------------------
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int unsigned         CTRL_W   = 8,
    parameter int unsigned         DATA_W   = 96,
    parameter logic [CTRL_W-1:0]   NOP_CTRL = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    skid_state_e       state_r;
    skid_state_e       state_nx_s;
    logic              in_ready_r;
    logic              out_valid_r;

    logic              accept_s;
    logic              fire_s;

    logic              main_ld_s;
    logic [CTRL_W-1:0] main_ctrl_s;
    logic [DATA_W-1:0] main_data_s;
    logic [CTRL_W-1:0] main_ctrl_q_s;
    logic [DATA_W-1:0] main_data_q_s;

    logic              skid_ld_s;
    logic [CTRL_W-1:0] skid_ctrl_s;
    logic [DATA_W-1:0] skid_data_s;
    logic [CTRL_W-1:0] skid_ctrl_q_s;
    logic [DATA_W-1:0] skid_data_q_s;

    assign accept_s = in_valid & in_ready_r;
    assign fire_s   = out_valid_r & out_ready;

    // Next-state and register load decode. Emptying a register only rewrites
    // its control field to NOP_CTRL; the data field is fed back unchanged.
    always_comb begin
        state_nx_s  = state_r;
        main_ld_s   = 1'b0;
        main_ctrl_s = in_ctrl;
        main_data_s = in_data;
        skid_ld_s   = 1'b0;
        skid_ctrl_s = in_ctrl;
        skid_data_s = in_data;

        if (flush) begin
            // A same-cycle accept is dropped; a same-cycle fire was delivered.
            state_nx_s  = ST_EMPTY;
            main_ld_s   = 1'b1;
            main_ctrl_s = NOP_CTRL;
            main_data_s = main_data_q_s;
            skid_ld_s   = 1'b1;
            skid_ctrl_s = NOP_CTRL;
            skid_data_s = skid_data_q_s;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nx_s = ST_ONE;
                        main_ld_s  = 1'b1;
                    end else begin
                        state_nx_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && fire_s) begin
                        state_nx_s = ST_ONE;
                        main_ld_s  = 1'b1;
                    end else if (accept_s) begin
                        state_nx_s = ST_TWO;
                        skid_ld_s  = 1'b1;
                    end else if (fire_s) begin
                        state_nx_s  = ST_EMPTY;
                        main_ld_s   = 1'b1;
                        main_ctrl_s = NOP_CTRL;
                        main_data_s = main_data_q_s;
                    end else begin
                        state_nx_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a fire can move the state.
                    if (fire_s) begin
                        state_nx_s  = ST_ONE;
                        main_ld_s   = 1'b1;
                        main_ctrl_s = skid_ctrl_q_s;
                        main_data_s = skid_data_q_s;
                        skid_ld_s   = 1'b1;
                        skid_ctrl_s = NOP_CTRL;
                        skid_data_s = skid_data_q_s;
                    end else begin
                        state_nx_s = ST_TWO;
                    end
                end
                default: begin
                    state_nx_s  = ST_EMPTY;
                    main_ld_s   = 1'b1;
                    main_ctrl_s = NOP_CTRL;
                    main_data_s = main_data_q_s;
                    skid_ld_s   = 1'b1;
                    skid_ctrl_s = NOP_CTRL;
                    skid_data_s = skid_data_q_s;
                end
            endcase
        end
    end

    // State register plus handshake flops precomputed from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s != ST_TWO);
            out_valid_r <= (state_nx_s != ST_EMPTY);
        end
    end

    pipe_entry_reg #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .NOP_CTRL (NOP_CTRL)
    ) u_main (
        .clk    (clk),
        .reset  (reset),
        .load   (main_ld_s),
        .ctrl_d (main_ctrl_s),
        .data_d (main_data_s),
        .ctrl_q (main_ctrl_q_s),
        .data_q (main_data_q_s)
    );

    pipe_entry_reg #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .NOP_CTRL (NOP_CTRL)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (skid_ld_s),
        .ctrl_d (skid_ctrl_s),
        .data_d (skid_data_s),
        .ctrl_q (skid_ctrl_q_s),
        .data_q (skid_data_q_s)
    );

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_ctrl  = main_ctrl_q_s;
    assign out_data  = main_data_q_s;
    assign occupancy = occ_of_state(state_r);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_skid
// Self-checking bench for pipe_stage_skid: default-width instance driven by
// scenario tasks with a scoreboard, plus a narrow instance with a non-zero
// bubble encoding.
// ----------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int CW = 8;
    localparam int DW = 96;
    typedef logic [CW+DW-1:0] ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    logic          p_flush = 1'b0;
    logic          p_in_valid = 1'b0;
    logic          p_in_ready;
    logic [2:0]    p_in_ctrl = 3'b000;
    logic [31:0]   p_in_data = 32'h0;
    logic          p_out_valid;
    logic          p_out_ready = 1'b0;
    logic [2:0]    p_out_ctrl;
    logic [31:0]   p_out_data;
    logic [1:0]    p_occupancy;

    ent_t exp_q[$];      // entries currently held, in acceptance order
    ent_t exp_out_q[$];  // expected entry for each delivery
    ent_t got_q[$];      // observed entry for each delivery
    int   spurious = 0;
    int   checks = 0;
    int   errors = 0;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .NOP_CTRL(8'h00)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_stage_skid #(.CTRL_W(3), .DATA_W(32), .NOP_CTRL(3'b111)) dut_p (
        .clk(clk), .reset(reset), .flush(p_flush),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .in_ctrl(p_in_ctrl), .in_data(p_in_data),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .out_ctrl(p_out_ctrl), .out_data(p_out_data),
        .occupancy(p_occupancy)
    );

    always #5 clk = ~clk;

    // Scoreboard capture: record deliveries and track held entries.
    always @(posedge clk) begin
        if (!reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                got_q.push_back({out_ctrl, out_data});
                if (exp_q.size() > 0) exp_out_q.push_back(exp_q.pop_front());
                else spurious++;
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
        end
    end

    function automatic logic [DW-1:0] mk(input int i);
        logic [DW-1:0] v;
        v = 96'hA000_0000_0000_0000_0000_0000;
        v[7:0] = 8'(i);
        return v;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_ctrl !== 8'h00) begin errors++; $display("FAIL reset_out_ctrl: got %h want 00", out_ctrl); end
        checks++; if (out_data !== 96'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        checks++; if (p_out_ctrl !== 3'b111) begin errors++; $display("FAIL reset_p_ctrl: got %b want 111", p_out_ctrl); end
        reset = 1'b1;
    endtask

    task automatic test_flow();
        int base = got_q.size();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i > 1) begin
                checks++; if (out_valid !== 1'b1 || occupancy !== 2'd1) begin errors++; $display("FAIL flow_bubble: valid %b occ %0d want 1/1", out_valid, occupancy); end
                checks++; if (out_data !== mk(i - 1) || out_ctrl !== 8'h15) begin errors++; $display("FAIL flow_out: got %h/%h want 15/%h", out_ctrl, out_data, mk(i - 1)); end
            end
            in_valid = 1'b1; in_ctrl = 8'h15; in_data = mk(i);
        end
        @(negedge clk);
        checks++; if (out_data !== mk(5) || out_valid !== 1'b1) begin errors++; $display("FAIL flow_last: got %b/%h want 1/%h", out_valid, out_data, mk(5)); end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || occupancy !== 2'd0) begin errors++; $display("FAIL flow_idle: valid %b ctrl %h occ %0d want 0/00/0", out_valid, out_ctrl, occupancy); end
        checks++; if (got_q.size() != base + 5) begin errors++; $display("FAIL flow_count: got %0d want %0d", got_q.size() - base, 5); end
        for (int k = 0; k < 5 && base + k < got_q.size(); k++) begin
            checks++; if (got_q[base + k] !== {8'h15, mk(k + 1)} || got_q[base + k] !== exp_out_q[base + k]) begin errors++; $display("FAIL flow_sb[%0d]: got %h want %h", k, got_q[base + k], {8'h15, mk(k + 1)}); end
        end
    endtask

    task automatic test_backpressure();
        int base = got_q.size();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_ctrl = 8'h21; in_data = mk(8'h11);
        @(negedge clk);
        checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_one: occ %0d rdy %b want 1/1", occupancy, in_ready); end
        in_ctrl = 8'h22; in_data = mk(8'h12);
        @(negedge clk);
        checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_two: occ %0d rdy %b want 2/0", occupancy, in_ready); end
        checks++; if (out_ctrl !== 8'h21 || out_data !== mk(8'h11)) begin errors++; $display("FAIL bp_head: got %h/%h want 21/%h", out_ctrl, out_data, mk(8'h11)); end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || occupancy !== 2'd1) begin errors++; $display("FAIL bp_recover: rdy %b occ %0d want 1/1", in_ready, occupancy); end
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 8'h22 || out_data !== mk(8'h12)) begin errors++; $display("FAIL bp_second: got %b/%h/%h want 1/22/%h", out_valid, out_ctrl, out_data, mk(8'h12)); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL bp_empty: valid %b occ %0d want 0/0", out_valid, occupancy); end
        checks++; if (got_q.size() != base + 2) begin errors++; $display("FAIL bp_count: got %0d want 2", got_q.size() - base); end
        for (int k = 0; k < 2 && base + k < got_q.size(); k++) begin
            checks++; if (got_q[base + k] !== {8'h21 + 8'(k), mk(8'h11 + k)} || got_q[base + k] !== exp_out_q[base + k]) begin errors++; $display("FAIL bp_sb[%0d]: got %h want %h", k, got_q[base + k], {8'h21 + 8'(k), mk(8'h11 + k)}); end
        end
    endtask

    task automatic test_flush();
        int base = got_q.size();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_ctrl = 8'h31; in_data = mk(8'h31);
        @(negedge clk);
        in_ctrl = 8'h32; in_data = mk(8'h32);
        @(negedge clk);
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_setup: occ %0d want 2", occupancy); end
        flush = 1'b1; in_ctrl = 8'h33; in_data = mk(8'h33);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || occupancy !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_two: valid %b ctrl %h occ %0d rdy %b want 0/00/0/1", out_valid, out_ctrl, occupancy, in_ready); end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (got_q.size() != base || out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak: got %0d deliveries want 0", got_q.size() - base); end
        // Flush in ONE with a simultaneous accept (dropped) and fire (delivered).
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h44; in_data = mk(8'h44);
        @(negedge clk);
        out_ready = 1'b1; flush = 1'b1; in_ctrl = 8'h45; in_data = mk(8'h45);
        @(negedge clk);
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_one: valid %b occ %0d rdy %b want 0/0/1", out_valid, occupancy, in_ready); end
        in_ctrl = 8'h46; in_data = mk(8'h46);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== mk(8'h46)) begin errors++; $display("FAIL flush_reaccept: got %b/%h want 1/%h", out_valid, out_data, mk(8'h46)); end
        @(negedge clk);
        checks++; if (got_q.size() != base + 2) begin errors++; $display("FAIL flush_count: got %0d want 2", got_q.size() - base); end
        else begin
            checks++; if (got_q[base] !== {8'h44, mk(8'h44)} || got_q[base + 1] !== {8'h46, mk(8'h46)}) begin errors++; $display("FAIL flush_sb: got %h,%h want 44/46 entries", got_q[base], got_q[base + 1]); end
        end
    endtask

    task automatic test_back_to_back();
        int base = got_q.size();
        int idx = 0;
        int cycles = 0;
        logic will_acc = 1'b0;
        while (idx < 16 && cycles < 200) begin
            @(negedge clk);
            cycles++;
            checks++; if (occupancy !== 2'(exp_q.size()) || in_ready !== (exp_q.size() < 2) || out_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL b2b_state: occ %0d rdy %b valid %b model %0d", occupancy, in_ready, out_valid, exp_q.size()); end
            if (in_valid && will_acc) idx++;
            if (idx < 16) begin
                in_valid = 1'b1; in_ctrl = 8'h15 ^ 8'(idx); in_data = mk(8'h80 + idx);
                will_acc = in_ready;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(1, 0));
        end
        checks++; if (cycles >= 200) begin errors++; $display("FAIL b2b_timeout: accepted %0d want 16", idx); end
        in_valid = 1'b0; out_ready = 1'b1;
        cycles = 0;
        while (occupancy != 2'd0 && cycles < 10) begin @(negedge clk); cycles++; end
        @(negedge clk);
        checks++; if (got_q.size() != base + 16) begin errors++; $display("FAIL b2b_count: got %0d want 16", got_q.size() - base); end
        for (int k = 0; k < 16 && base + k < got_q.size(); k++) begin
            checks++; if (got_q[base + k] !== {8'h15 ^ 8'(k), mk(8'h80 + k)} || got_q[base + k] !== exp_out_q[base + k]) begin errors++; $display("FAIL b2b_sb[%0d]: got %h want %h", k, got_q[base + k], {8'h15 ^ 8'(k), mk(8'h80 + k)}); end
        end
    endtask

    task automatic test_async_reset();
        int base = got_q.size();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_ctrl = 8'h5A; in_data = mk(8'h91);
        @(negedge clk);
        in_data = mk(8'h92);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL ar_setup: occ %0d want 2", occupancy); end
        #2 reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 96'h0 || occupancy !== 2'd0) begin errors++; $display("FAIL ar_immediate: rdy %b valid %b ctrl %h data %h occ %0d", in_ready, out_valid, out_ctrl, out_data, occupancy); end
        @(negedge clk);
        in_valid = 1'b1; in_ctrl = 8'hEE; in_data = mk(8'hEE);
        @(negedge clk);
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL ar_ignore: occ %0d valid %b want 0/0", occupancy, out_valid); end
        reset = 1'b1; in_ctrl = 8'h5B; in_data = mk(8'h93); out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 8'h5B || out_data !== mk(8'h93)) begin errors++; $display("FAIL ar_first: got %b/%h/%h want 1/5b/%h", out_valid, out_ctrl, out_data, mk(8'h93)); end
        @(negedge clk);
        checks++; if (got_q.size() != base + 1 || got_q[got_q.size() - 1] !== {8'h5B, mk(8'h93)}) begin errors++; $display("FAIL ar_sb: %0d deliveries, want 1 of entry 93", got_q.size() - base); end
        checks++; if (spurious != 0) begin errors++; $display("FAIL sb_spurious: got %0d want 0", spurious); end
    endtask

    task automatic test_params();
        @(negedge clk);
        checks++; if (p_out_ctrl !== 3'b111 || p_out_valid !== 1'b0) begin errors++; $display("FAIL p_idle: ctrl %b valid %b want 111/0", p_out_ctrl, p_out_valid); end
        p_in_valid = 1'b1; p_in_ctrl = 3'b010; p_in_data = 32'hDEAD_BEEF; p_out_ready = 1'b1;
        @(negedge clk);
        p_in_valid = 1'b0;
        checks++; if (p_out_valid !== 1'b1 || p_out_ctrl !== 3'b010 || p_out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL p_pass: got %b/%b/%h want 1/010/deadbeef", p_out_valid, p_out_ctrl, p_out_data); end
        @(negedge clk);
        checks++; if (p_out_valid !== 1'b0 || p_out_ctrl !== 3'b111 || p_out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL p_drain: got %b/%b/%h want 0/111/deadbeef", p_out_valid, p_out_ctrl, p_out_data); end
        p_in_valid = 1'b1; p_in_ctrl = 3'b101; p_in_data = 32'h1234_5678; p_out_ready = 1'b0;
        @(negedge clk);
        p_in_valid = 1'b0;
        checks++; if (p_out_ctrl !== 3'b101 || p_out_data !== 32'h1234_5678) begin errors++; $display("FAIL p_hold: got %b/%h want 101/12345678", p_out_ctrl, p_out_data); end
        p_flush = 1'b1;
        @(negedge clk);
        p_flush = 1'b0;
        checks++; if (p_out_ctrl !== 3'b111 || p_out_valid !== 1'b0 || p_occupancy !== 2'd0 || p_in_ready !== 1'b1 || p_out_data !== 32'h1234_5678) begin errors++; $display("FAIL p_flush: got %b/%b/%0d/%b/%h want 111/0/0/1/12345678", p_out_ctrl, p_out_valid, p_occupancy, p_in_ready, p_out_data); end
    endtask

    initial begin
        test_reset();
        test_flow();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage buffer for the processor pipeline. It replaces fixed stall/kill stage registers with a valid/ready handshake and a 2-entry skid buffer, so back-pressure is absorbed without a combinational ready path. It adds a synchronous flush that turns every held entry into a bubble. One instance sits between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with the control bundle and the data bundle sized per boundary.

## Interface
- `CTRL_W`, default 8: width of the control bundle (RegWr, MemWr, MemRd, WBdata, ALUop, …).
- `DATA_W`, default 96: width of the data bundle (operands, immediate, NPC, register indices).
- `NOP_CTRL`, default 0: control value that encodes a bubble.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low; 0 clears all state immediately.
- `flush`, in, 1: synchronous kill of all held entries.
- `in_valid`, in, 1: upstream offers an entry.
- `in_ready`, out, 1: buffer can accept; driven directly from a flop.
- `in_ctrl`, in, CTRL_W: upstream control bundle.
- `in_data`, in, DATA_W: upstream data bundle.
- `out_valid`, out, 1: an entry is presented downstream; driven directly from a flop.
- `out_ready`, in, 1: downstream consumes the presented entry.
- `out_ctrl`, out, CTRL_W: control of the head entry; NOP_CTRL whenever out_valid=0.
- `out_data`, out, DATA_W: data of the head entry; holds its last value when invalid.
- `occupancy`, out, 2: number of held entries (0..2).

## Operation
- Handshake terms:
  - Accept = in_valid & in_ready.
  - Fire = out_valid & out_ready.
  - A transfer happens on the edge where its term is 1.
- Storage: a main register that drives the outputs, and a skid register.
- State machine:
  - EMPTY (occ 0):
    - accept → ONE, main←in.
  - ONE (occ 1):
    - accept & fire → ONE, main←in.
    - accept only → TWO, skid←in.
    - fire only → EMPTY.
    - neither → hold.
  - TWO (occ 2):
    - in_ready=0, so there is no accept.
    - fire → ONE, main←skid.
    - else hold.
- in_ready = (next state ≠ TWO), registered. out_valid = (next state ≠ EMPTY), registered.
- flush=1 has the highest priority:
  - Next state is EMPTY.
  - An entry accepted in the same cycle is consumed and dropped, and upstream treats it as transferred.
  - A fire in the same cycle counts as delivered.
- Data registers are not cleared on flush. Bubbles are produced by forcing the control bundle to NOP_CTRL.
- Order is strictly FIFO. No entry is duplicated or lost except through flush.
- Values on in_valid/in_ctrl/in_data while reset=0 are ignored.

## Timing
- Reset values (asynchronous, held while reset=0):
  - in_ready=1, out_valid=0, out_ctrl=NOP_CTRL, out_data=0, occupancy=0.
  - Both registers are cleared to NOP_CTRL / 0.
- Latency: an entry accepted at edge N is presented (out_valid=1) after edge N, so it can fire at edge N+1.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Back-pressure: when out_ready drops, at most one further accept lands in the skid register, and in_ready falls after that edge.
- Recovery: when out_ready rises in TWO, in_ready returns 1 one edge later. No bubble is inserted when the skid drains into main.
- Flush at edge N: out_valid=0, out_ctrl=NOP_CTRL and in_ready=1 after edge N. A new accept is possible at edge N+1.
- Reset asserted mid-transfer: every held entry is lost and outputs take their reset values at once, without waiting for a clock edge.
- No combinational path from in_* to out_*, or from out_ready to in_ready.

## Structure
- Shared pipeline package holds:
  - the state enum (EMPTY/ONE/TWO);
  - the NOP_CTRL encoding;
  - per-boundary CTRL_W/DATA_W constants (IF_ID, ID_EX, EX_MEM, MEM_WB);
  - the bit-position constants used to pack and unpack the bundles.
- One sub-module: `pipe_entry_reg`, a CTRL_W+DATA_W register with load enable and an asynchronous active-low clear to NOP_CTRL/0. It is instantiated twice (main, skid).
- The state machine and the ready/valid flops live in the top module.

## Test plan
- Reset/flow: release reset, then drive in_valid=1 with ctrl=0x15 and data=0xA…01, …05 on consecutive cycles, out_ready=1 → outputs appear in order one cycle later, occupancy stays 1, and there are no bubbles.
- Back-pressure:
  - Fill with entries 1,2 while out_ready=0 → occupancy=2 and in_ready=0 after the second accept.
  - Then set out_ready=1 → 1 then 2 emerge on consecutive cycles, and in_ready returns 1 one cycle after the first fire.
- Flush:
  - In state TWO, assert flush together with in_valid=1 → next cycle out_valid=0, out_ctrl=0x00, occupancy=0, in_ready=1.
  - Neither the held entries nor the simultaneous input ever appear.
- Simultaneous accept and fire in ONE, repeated 16 cycles with random out_ready → the scoreboard matches the input order exactly, with no loss or duplication.
- Asynchronous reset: pull reset low between clock edges while in TWO → outputs go to reset values immediately; after release the first accepted entry is the first output.
- Parameters: instantiate with CTRL_W=3, DATA_W=32, NOP_CTRL=3'b111 → idle and flushed out_ctrl equals 3'b111, and data passes through bit-exact.
